// File: rtl/multi_cycle_ctrl_pkg.sv
// rtl/multi_cycle_ctrl_pkg.sv - opcode, state, pc_src and halt-cause codes for multi_cycle_ctrl
package multi_cycle_ctrl_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_L      = 7'b0000011;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   localparam logic [1:0] PCS_SEQ  = 2'd0;
   localparam logic [1:0] PCS_BR   = 2'd1;
   localparam logic [1:0] PCS_JAL  = 2'd2;
   localparam logic [1:0] PCS_JALR = 2'd3;

   localparam logic [1:0] HC_NONE    = 2'd0;
   localparam logic [1:0] HC_ECALL   = 2'd1;
   localparam logic [1:0] HC_EBREAK  = 2'd2;
   localparam logic [1:0] HC_ILLEGAL = 2'd3;

   // SYSTEM is deliberately absent: it is handled as a halt, not executed
   function automatic logic is_rv32i_op(input logic [6:0] op);
      case (op)
         OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// rtl/multi_cycle_ctrl_if.sv - decoder/memory handshake and strobe bundle for multi_cycle_ctrl
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32) ();
   logic [6:0]       op;
   logic             sys_bit;
   logic             illegal;
   logic             br_taken;
   logic             imem_ready;
   logic             dmem_ready;
   logic             imem_req;
   logic             ir_we;
   logic             id_en;
   logic             ex_en;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_we;
   logic             pc_we;
   logic [1:0]       pc_src;
   logic [31:0]      pc_reset_val;
   logic             halted;
   logic [1:0]       halt_cause;
   logic [CNT_W-1:0] instret;
   logic [2:0]       state;

   modport master (
      output op, sys_bit, illegal, br_taken, imem_ready, dmem_ready,
      input  imem_req, ir_we, id_en, ex_en, dmem_req, dmem_we, rf_we, pc_we, pc_src,
             pc_reset_val, halted, halt_cause, instret, state
   );

   modport slave (
      input  op, sys_bit, illegal, br_taken, imem_ready, dmem_ready,
      output imem_req, ir_we, id_en, ex_en, dmem_req, dmem_we, rf_we, pc_we, pc_src,
             pc_reset_val, halted, halt_cause, instret, state
   );
endinterface

// File: rtl/multi_cycle_ctrl_instret_cnt.sv
// rtl/multi_cycle_ctrl_instret_cnt.sv - wrapping retired-instruction counter with increment enable
module multi_cycle_ctrl_instret_cnt #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_count
);
   localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_count <= '0;
      else if (i_en)
         r_count <= r_count + ONE;
   end

   assign o_count = r_count;
endmodule

// File: rtl/multi_cycle_ctrl.sv
// rtl/multi_cycle_ctrl.sv - FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I core
module multi_cycle_ctrl
   import multi_cycle_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   multi_cycle_ctrl_if.slave bus
);
   state_t           r_state;
   logic [6:0]       r_op_q;
   logic [1:0]       r_halt_cause;
   logic             w_imem_req, w_ir_we, w_id_en, w_ex_en;
   logic             w_dmem_req, w_dmem_we, w_rf_we, w_pc_we, w_inc;
   logic [1:0]       w_pc_src;
   logic [CNT_W-1:0] w_instret;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_FETCH;
         r_op_q       <= '0;
         r_halt_cause <= HC_NONE;
      end else begin
         case (r_state)
            ST_FETCH:  if (bus.imem_ready) r_state <= ST_DECODE;
            ST_DECODE: begin
               r_op_q <= bus.op;
               if (bus.op == OP_SYSTEM) begin
                  r_state      <= ST_HALT;
                  r_halt_cause <= bus.sys_bit ? HC_EBREAK : HC_ECALL;
               end else if (bus.illegal || !is_rv32i_op(bus.op)) begin
                  r_state      <= ST_HALT;
                  r_halt_cause <= HC_ILLEGAL;
               end else begin
                  r_state <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (r_op_q == OP_L || r_op_q == OP_S) r_state <= ST_MEM;
               else if (r_op_q == OP_B)              r_state <= ST_FETCH;
               else                                  r_state <= ST_WB;
            end
            ST_MEM:  if (bus.dmem_ready) r_state <= (r_op_q == OP_S) ? ST_FETCH : ST_WB;
            ST_WB:   r_state <= ST_FETCH;
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   // Strobes are masked while rst_n is low so a reset mid-access never issues a write
   always_comb begin
      w_imem_req = 1'b0;
      w_ir_we    = 1'b0;
      w_id_en    = 1'b0;
      w_ex_en    = 1'b0;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_rf_we    = 1'b0;
      w_pc_we    = 1'b0;
      w_pc_src   = PCS_SEQ;
      w_inc      = 1'b0;
      if (rst_n) begin
         case (r_state)
            ST_FETCH: begin
               w_imem_req = 1'b1;
               w_ir_we    = bus.imem_ready;
            end
            ST_DECODE: w_id_en = 1'b1;
            ST_EXEC: begin
               w_ex_en = 1'b1;
               if (r_op_q == OP_B) begin
                  w_pc_we  = 1'b1;
                  w_pc_src = bus.br_taken ? PCS_BR : PCS_SEQ;
                  w_inc    = 1'b1;
               end
            end
            ST_MEM: begin
               w_dmem_req = 1'b1;
               w_dmem_we  = (r_op_q == OP_S);
               if (bus.dmem_ready && r_op_q == OP_S) begin
                  w_pc_we = 1'b1;
                  w_inc   = 1'b1;
               end
            end
            ST_WB: begin
               w_rf_we = 1'b1;
               w_pc_we = 1'b1;
               w_inc   = 1'b1;
               if (r_op_q == OP_JAL)       w_pc_src = PCS_JAL;
               else if (r_op_q == OP_JALR) w_pc_src = PCS_JALR;
            end
            default: ;
         endcase
      end
   end

   multi_cycle_ctrl_instret_cnt #(.CNT_W(CNT_W)) u_instret (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_inc),
      .o_count (w_instret)
   );

   assign bus.imem_req     = w_imem_req;
   assign bus.ir_we        = w_ir_we;
   assign bus.id_en        = w_id_en;
   assign bus.ex_en        = w_ex_en;
   assign bus.dmem_req     = w_dmem_req;
   assign bus.dmem_we      = w_dmem_we;
   assign bus.rf_we        = w_rf_we;
   assign bus.pc_we        = w_pc_we;
   assign bus.pc_src       = w_pc_src;
   assign bus.pc_reset_val = RESET_PC;
   assign bus.halted       = (r_state == ST_HALT);
   assign bus.halt_cause   = r_halt_cause;
   assign bus.instret      = w_instret;
   assign bus.state        = r_state;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb/tb_multi_cycle_ctrl.sv - randomized instruction-level bench for multi_cycle_ctrl
module tb_multi_cycle_ctrl;
   localparam int          CW  = 6;
   localparam logic [31:0] RPC = 32'h8000_0100;
   localparam int C_B = 0, C_ALU = 1, C_S = 2, C_L = 3, C_SYS = 4, C_ILL = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [CW-1:0] m_instret = '0;
   logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                                 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

   always #5 clk = ~clk;

   multi_cycle_ctrl_if #(.CNT_W(CW)) bus ();

   multi_cycle_ctrl #(.RESET_PC(RPC), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   wire [7:0] w_strobes = {bus.imem_req, bus.ir_we, bus.id_en, bus.ex_en,
                           bus.dmem_req, bus.dmem_we, bus.rf_we, bus.pc_we};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int op_class(input logic [6:0] op, input logic ill);
      if (op == 7'b1110011) return C_SYS;
      if (ill) return C_ILL;
      case (op)
         7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111: return C_ALU;
         7'b0000011: return C_L;
         7'b0100011: return C_S;
         7'b1100011: return C_B;
         default:    return C_ILL;
      endcase
   endfunction

   // Expected state walk, one nibble {1,state} per cycle
   function automatic logic [63:0] exp_seq(input int cls, input int iw, input int dw);
      logic [63:0] s = '0;
      for (int i = 0; i <= iw; i++) s = {s[59:0], 4'h8};
      s = {s[59:0], 4'h9};
      if (cls == C_SYS || cls == C_ILL) return {s[59:0], 4'hD};
      s = {s[59:0], 4'hA};
      if (cls == C_L || cls == C_S)
         for (int i = 0; i <= dw; i++) s = {s[59:0], 4'hB};
      if (cls == C_L || cls == C_ALU) s = {s[59:0], 4'hC};
      return s;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      #1 check("rst_cycle_strobes", w_strobes, 8'h00);
      @(posedge clk);
      #1;
      check("rst_state", bus.state, 3'd0);
      check("rst_halted", bus.halted, 1'b0);
      check("rst_cause", bus.halt_cause, 2'd0);
      check("rst_instret", bus.instret, '0);
      m_instret = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_instr(input logic [6:0] op, input logic sb, input logic ill,
                            input logic bt, input int iw, input int dw);
      int cls, cyc, exp_cyc, seen_i, seen_d;
      int n_ir, n_id, n_ex, n_pc, n_rf, n_dwe, n_ireq, n_dreq, n_both;
      logic done;
      logic [1:0] src, exp_src, exp_cause;
      logic [63:0] seq;
      cls = op_class(op, ill);
      {cyc, seen_i, seen_d, n_ir, n_id, n_ex, n_pc, n_rf, n_dwe, n_ireq, n_dreq, n_both} = '0;
      done = 1'b0;
      src = 2'd0;
      seq = '0;
      bus.op = op;
      bus.sys_bit = sb;
      bus.illegal = ill;
      bus.br_taken = bt;
      while (!done && cyc < 40) begin
         @(negedge clk);
         bus.imem_ready = bus.imem_req ? (seen_i >= iw) : 1'($urandom_range(1));
         bus.dmem_ready = bus.dmem_req ? (seen_d >= dw) : 1'($urandom_range(1));
         #1;
         cyc++;
         seq = {seq[59:0], 1'b1, bus.state};
         if (bus.imem_req) seen_i++;
         if (bus.dmem_req) seen_d++;
         n_ir += int'(bus.ir_we);
         n_id += int'(bus.id_en);
         n_ex += int'(bus.ex_en);
         n_pc += int'(bus.pc_we);
         n_rf += int'(bus.rf_we);
         n_dwe += int'(bus.dmem_we);
         n_ireq += int'(bus.imem_req);
         n_dreq += int'(bus.dmem_req);
         if (bus.pc_we && bus.rf_we) n_both++;
         if (bus.pc_we) src = bus.pc_src;
         if (bus.pc_we || bus.halted) done = 1'b1;
      end
      case (cls)
         C_B:     exp_cyc = 3 + iw;
         C_ALU:   exp_cyc = 4 + iw;
         C_S:     exp_cyc = 4 + iw + dw;
         C_L:     exp_cyc = 5 + iw + dw;
         default: exp_cyc = 3 + iw;
      endcase
      exp_src = (cls == C_B) ? {1'b0, bt} : (op == 7'b1101111) ? 2'd2 :
                (op == 7'b1100111 && cls == C_ALU) ? 2'd3 : 2'd0;
      check($sformatf("done op=%b", op), done, 1'b1);
      check($sformatf("cycles op=%b", op), cyc, exp_cyc);
      check($sformatf("states op=%b", op), seq, exp_seq(cls, iw, dw));
      check("ir_we_count", n_ir, 1);
      check("id_en_count", n_id, 1);
      check("imem_req_cycles", n_ireq, 1 + iw);
      check("ex_en_count", n_ex, (cls >= C_SYS) ? 0 : 1);
      check("pc_we_count", n_pc, (cls >= C_SYS) ? 0 : 1);
      check("rf_we_count", n_rf, (cls == C_ALU || cls == C_L) ? 1 : 0);
      check("rf_pc_coincide", n_both, n_rf);
      check("dmem_we_cycles", n_dwe, (cls == C_S) ? 1 + dw : 0);
      check("dmem_req_cycles", n_dreq, (cls == C_S || cls == C_L) ? 1 + dw : 0);
      if (cls < C_SYS) check($sformatf("pc_src op=%b", op), src, exp_src);
      @(posedge clk);
      #1;
      if (cls < C_SYS) m_instret = m_instret + 1'b1;
      check("instret", bus.instret, m_instret);
      if (cls >= C_SYS) begin
         exp_cause = (cls == C_SYS) ? (sb ? 2'd2 : 2'd1) : 2'd3;
         repeat (3) begin
            @(negedge clk);
            bus.imem_ready = 1'($urandom_range(1));
            bus.dmem_ready = 1'($urandom_range(1));
            #1;
            check("halt_state", bus.state, 3'd5);
            check("halt_flag", bus.halted, 1'b1);
            check("halt_cause", bus.halt_cause, exp_cause);
            check("halt_strobes", w_strobes, 8'h00);
            check("halt_instret", bus.instret, m_instret);
         end
      end
   endtask

   initial begin
      int cnt;
      bus.op = '0;
      bus.sys_bit = 1'b0;
      bus.illegal = 1'b0;
      bus.br_taken = 1'b0;
      bus.imem_ready = 1'b0;
      bus.dmem_ready = 1'b0;
      do_reset();
      check("pc_reset_val", bus.pc_reset_val, RPC);

      run_instr(7'b0110011, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b0000011, 1'b0, 1'b0, 1'b0, 0, 2);
      run_instr(7'b1100011, 1'b0, 1'b0, 1'b1, 0, 0);
      run_instr(7'b1100011, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b1100111, 1'b0, 1'b0, 1'b0, 3, 0);
      run_instr(7'b1101111, 1'b0, 1'b0, 1'b0, 1, 0);
      run_instr(7'b0100011, 1'b0, 1'b0, 1'b0, 0, 0);
      run_instr(7'b1110011, 1'b1, 1'b0, 1'b0, 0, 0);
      do_reset();
      run_instr(7'b0110011, 1'b0, 1'b1, 1'b0, 1, 0);
      do_reset();
      run_instr(7'b1110011, 1'b0, 1'b0, 1'b0, 2, 0);
      do_reset();

      // Store held in MEM, then reset without letting the write complete
      run_instr(7'b0010011, 1'b0, 1'b0, 1'b0, 0, 0);
      bus.op = 7'b0100011;
      cnt = 0;
      for (int c = 0; c < 20 && cnt < 2; c++) begin
         @(negedge clk);
         bus.imem_ready = bus.imem_req;
         bus.dmem_ready = 1'b0;
         #1;
         if (bus.state == 3'd3) cnt++;
      end
      check("mid_mem_reached", cnt, 2);
      do_reset();
      @(negedge clk);
      bus.imem_ready = 1'b0;
      #1;
      check("post_rst_state", bus.state, 3'd0);
      check("post_rst_dmem_we", bus.dmem_we, 1'b0);
      check("post_rst_imem_req", bus.imem_req, 1'b1);

      // Long halt-free run so the narrow counter wraps
      for (int k = 0; k < 75; k++)
         run_instr(legal_ops[$urandom_range(0, 8)], 1'($urandom_range(1)), 1'b0,
                   1'($urandom_range(1)), $urandom_range(0, 3), $urandom_range(0, 3));

      for (int k = 0; k < 150; k++) begin
         int pick;
         logic [6:0] op;
         logic ill;
         pick = $urandom_range(0, 49);
         ill = 1'b0;
         if (pick < 46)       op = legal_ops[pick % 9];
         else if (pick == 46) op = 7'b1110011;
         else if (pick == 47) op = 7'($urandom);
         else begin
            op = legal_ops[$urandom_range(0, 8)];
            ill = (pick == 48);
         end
         if (op == 7'b1110011) ill = 1'b0;
         run_instr(op, 1'($urandom_range(1)), ill, 1'($urandom_range(1)),
                   $urandom_range(0, 3), $urandom_range(0, 3));
         if (op_class(op, ill) >= C_SYS) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
